// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with prefetch FIFO
// Issues word reads to a synchronous-read imem and hands instructions with their PCs to decode.

module prefetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload needs no reset: it is only observed through a nonzero count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 7,
    parameter int          FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [IMEM_ADDR_W-1:0] imem_rd_addr0,
    output logic                   imem_rd_en,
    input  logic [31:0]            imem_rd_dout0,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic [31:0]            inst,
    output logic [31:0]            inst_pc,
    output logic                   inst_valid,
    output logic                   misalign_fault
);
    localparam int          CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state;
    logic [31:0]      fpc;
    logic             inflight;
    logic [31:0]      inflight_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W:0]   occ_next;
    logic [63:0]      head_data;
    logic             head_valid;
    logic             pop;
    logic             push;
    logic             issue;

    always_comb begin
        head_valid = (count != '0) && !redirect;
        pop        = head_valid && !stall;
        push       = inflight && !redirect;
        // In FULL a pop this cycle frees the slot before the new word returns.
        issue      = !redirect && ((state == FETCH) || ((state == FULL) && pop));
        count_next = '0;
        if (!redirect) count_next = count + CNT_W'(push) - CNT_W'(pop);
        occ_next   = {1'b0, count_next} + (CNT_W + 1)'(issue);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) inflight_pc <= fpc;

            if (redirect)   fpc <= redirect_pc;
            else if (issue) fpc <= fpc + 32'd4;

            if (redirect)
                state <= (redirect_pc[1:0] != 2'b00) ? FAULT : FETCH;
            else if (state != FAULT)
                state <= (occ_next == (CNT_W + 1)'(FIFO_DEPTH)) ? FULL : FETCH;
        end
    end

    prefetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({imem_rd_dout0, inflight_pc}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

    assign imem_rd_en     = issue && rst;
    assign imem_rd_addr0  = fpc[IMEM_ADDR_W+1:2];
    assign inst_valid     = head_valid;
    assign inst           = head_valid ? head_data[63:32] : NOP;
    assign inst_pc        = head_valid ? head_data[31:0] : 32'h0;
    assign misalign_fault = (state == FAULT);
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit
// Synchronous-read memory model holds mem[i] = 32'h1000_0000 + i.

module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [6:0]  imem_rd_addr0;
    logic        imem_rd_en;
    logic [31:0] imem_rd_dout0 = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        misalign_fault;

    logic [31:0] mem [128];
    int n_vec = 0;
    int n_bad = 0;

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_ADDR_W (7),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_rd_addr0  (imem_rd_addr0),
        .imem_rd_en     (imem_rd_en),
        .imem_rd_dout0  (imem_rd_dout0),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .misalign_fault (misalign_fault)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rd_dout0 <= mem[imem_rd_addr0];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rp);
        @(posedge clk);
        #1;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        #1;
    endtask

    task automatic exp_inst(input logic [31:0] pc);
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst_pc", inst_pc, pc);
        chk("inst", inst, 32'h1000_0000 + ((pc >> 2) & 32'd127));
    endtask

    task automatic exp_none();
        chk("inst_valid_off", 32'(inst_valid), 32'd0);
        chk("inst_nop", inst, 32'h0000_0013);
        chk("inst_pc_zero", inst_pc, 32'h0);
    endtask

    task automatic exp_rd(input logic en, input logic [31:0] pc);
        chk("imem_rd_en", 32'(imem_rd_en), 32'(en));
        if (en) chk("imem_rd_addr0", 32'(imem_rd_addr0), (pc >> 2) & 32'd127);
    endtask

    task automatic exp_fault(input logic f);
        chk("misalign_fault", 32'(misalign_fault), 32'(f));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + 32'(i);

        // reset state
        repeat (3) @(posedge clk);
        #2;
        exp_none();
        exp_rd(1'b0, 32'h0);
        exp_fault(1'b0);

        // release: issue in cycles 0 and 1, first instruction in cycle 2
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_rd(1'b1, 32'h0);
        exp_none();
        drive(1'b0, 1'b0, 32'h0);
        exp_rd(1'b1, 32'h4);
        exp_none();
        drive(1'b0, 1'b0, 32'h0);
        exp_inst(32'h0);
        exp_rd(1'b1, 32'h8);

        // stall for 10 cycles: head PC 4 held, no issue
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            exp_inst(32'h4);
            exp_rd(1'b0, 32'h0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            exp_inst(32'h4 + 32'(4 * i));
            exp_rd(1'b1, 32'hC + 32'(4 * i));
        end

        // redirect to 0x40 with a read in flight
        drive(1'b0, 1'b1, 32'h40);
        exp_none();
        exp_rd(1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        exp_none();
        exp_rd(1'b1, 32'h40);
        drive(1'b0, 1'b0, 32'h0);
        exp_none();
        exp_rd(1'b1, 32'h44);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            exp_inst(32'h40 + 32'(4 * i));
        end

        // misaligned redirect, then recovery at 0x80
        drive(1'b0, 1'b1, 32'h42);
        exp_none();
        exp_fault(1'b0);
        exp_rd(1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            exp_fault(1'b1);
            exp_rd(1'b0, 32'h0);
            exp_none();
        end
        drive(1'b0, 1'b1, 32'h80);
        exp_fault(1'b1);
        exp_none();
        exp_rd(1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        exp_fault(1'b0);
        exp_none();
        exp_rd(1'b1, 32'h80);
        drive(1'b0, 1'b0, 32'h0);
        exp_none();
        drive(1'b0, 1'b0, 32'h0);
        exp_inst(32'h80);
        drive(1'b0, 1'b0, 32'h0);
        exp_inst(32'h84);

        // redirect with stall, then back-to-back redirects 0x10, 0x20
        drive(1'b1, 1'b1, 32'h10);
        exp_none();
        exp_rd(1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h20);
        exp_none();
        exp_rd(1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        exp_none();
        exp_rd(1'b1, 32'h20);
        drive(1'b0, 1'b0, 32'h0);
        exp_none();
        drive(1'b0, 1'b0, 32'h0);
        exp_inst(32'h20);
        drive(1'b0, 1'b0, 32'h0);
        exp_inst(32'h24);

        // asynchronous reset mid-stream, released before the next edge
        drive(1'b0, 1'b0, 32'h0);
        exp_inst(32'h28);
        #1;
        rst = 1'b0;
        #1;
        exp_none();
        exp_rd(1'b0, 32'h0);
        exp_fault(1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        exp_none();
        exp_rd(1'b1, 32'h4);
        drive(1'b0, 1'b0, 32'h0);
        exp_inst(32'h0);
        drive(1'b0, 1'b0, 32'h0);
        exp_inst(32'h4);

        // word index wraps past the top of the 128-word memory
        drive(1'b0, 1'b1, 32'h1FC);
        exp_none();
        drive(1'b0, 1'b0, 32'h0);
        exp_rd(1'b1, 32'h1FC);
        drive(1'b0, 1'b0, 32'h0);
        exp_rd(1'b1, 32'h200);
        chk("wrap_addr", 32'(imem_rd_addr0), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            exp_inst(32'h1FC + 32'(4 * i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
